risc_v_wait_memory: RTL

//   Byte-addressable RV32 data memory with a valid/ready request handshake, configurable wait states,

---
 rtl/risc_v_wait_memory_pkg.sv | 27 ++
 rtl/risc_v_wait_memory_byte_ram.sv | 25 ++
 rtl/risc_v_wait_memory.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/risc_v_wait_memory_pkg.sv
// Shared types for the wait-state data memory: access size codes, FSM states and a size helper.
package risc_v_wait_memory_pkg;

    // Encoding matches funct3[1:0] of RV32 loads/stores
    typedef enum logic [1:0] {
        SzByte    = 2'b00,
        SzHalf    = 2'b01,
        SzWord    = 2'b10,
        SzIllegal = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StResp
    } state_e;

    function automatic logic [2:0] size_bytes(input size_e sz);
        case (sz)
            SzByte:  return 3'd1;
            SzHalf:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/risc_v_wait_memory_byte_ram.sv
// Word-organised RAM with per-byte write enables and an asynchronous word read.
module risc_v_wait_memory_byte_ram #(
    parameter int unsigned Words = 256,
    parameter int unsigned IdxW  = 8
) (
    input  logic            clk_i,
    input  logic [3:0]      we_i,
    input  logic [IdxW-1:0] addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o
);

    logic [31:0] mem_q [Words];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/risc_v_wait_memory.sv
// RV32 data memory with valid/ready request handshake, configurable wait states,
// byte/half/word access with sign/zero extension, and misalignment/range error reporting.
module risc_v_wait_memory
    import risc_v_wait_memory_pkg::*;
#(
    parameter int unsigned Xlen       = 32,
    parameter int unsigned AddrWidth  = 10,
    parameter int unsigned MemBytes   = 1024,
    parameter int unsigned WaitStates = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [1:0]           req_size_i,
    input  logic                 req_unsigned_i,
    input  logic [Xlen-1:0]      req_wdata_i,
    output logic                 resp_valid_o,
    output logic [Xlen-1:0]      resp_rdata_o,
    output logic                 resp_error_o
);

    localparam int unsigned Words = MemBytes / 4;
    localparam int unsigned IdxW  = $clog2(Words);
    localparam logic [3:0] WaitLast = (WaitStates == 0) ? 4'd0 : 4'(WaitStates - 1);
    localparam logic [AddrWidth:0] MemLimit = (AddrWidth + 1)'(MemBytes);

    state_e                 state_q;
    logic [3:0]             cnt_q;
    logic                   write_q;
    logic [AddrWidth-1:0]   addr_q;
    size_e                  size_q;
    logic                   uns_q;
    logic [Xlen-1:0]        wdata_q;
    logic                   resp_valid_q;
    logic                   resp_error_q;
    logic [Xlen-1:0]        resp_rdata_q;

    logic [AddrWidth:0]     last_addr;
    logic                   misalign;
    logic                   out_of_range;
    logic                   err;
    logic [3:0]             be;
    logic [3:0]             ram_we;
    logic [Xlen-1:0]        lane_wdata;
    logic [Xlen-1:0]        ram_rdata;
    logic [Xlen-1:0]        shifted;
    logic [Xlen-1:0]        load_data;

    // Error check and lane steering operate on the latched request only
    always_comb begin
        last_addr    = {1'b0, addr_q} + (AddrWidth + 1)'(size_bytes(size_q) - 3'd1);
        out_of_range = (last_addr >= MemLimit);
        misalign     = 1'b0;
        be           = 4'b0000;
        lane_wdata   = wdata_q;
        case (size_q)
            SzByte: begin
                be         = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            SzHalf: begin
                misalign   = addr_q[0];
                be         = 4'b0011 << {addr_q[1], 1'b0};
                lane_wdata = {2{wdata_q[15:0]}};
            end
            SzWord: begin
                misalign   = |addr_q[1:0];
                be         = 4'b1111;
            end
            default: misalign = 1'b1;
        endcase
        err = misalign | out_of_range;
    end

    always_comb begin
        shifted = ram_rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            SzByte:  load_data = {{(Xlen-8){shifted[7] & ~uns_q}}, shifted[7:0]};
            SzHalf:  load_data = {{(Xlen-16){shifted[15] & ~uns_q}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // A reset landing on the ACCESS edge must not let the store commit
    assign ram_we = (state_q == StAccess && write_q && !err && !rst_i) ? be : 4'b0000;

    risc_v_wait_memory_byte_ram #(
        .Words (Words),
        .IdxW  (IdxW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (addr_q[IdxW+1:2]),
        .wdata_i (lane_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        write_q <= req_write_i;
                        addr_q  <= req_addr_i;
                        size_q  <= size_e'(req_size_i);
                        uns_q   <= req_unsigned_i;
                        wdata_q <= req_wdata_i;
                        cnt_q   <= 4'd0;
                        state_q <= (WaitStates == 0) ? StAccess : StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == WaitLast) begin
                        cnt_q   <= 4'd0;
                        state_q <= StAccess;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StAccess: begin
                    resp_valid_q <= 1'b1;
                    resp_error_q <= err;
                    resp_rdata_q <= (err || write_q) ? '0 : load_data;
                    state_q      <= StResp;
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = resp_valid_q;
    assign resp_error_o = resp_error_q;
    assign resp_rdata_o = resp_rdata_q;

endmodule
